// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter: two-requester round-robin burst reader in front of a
// synchronous ROM (one-cycle read latency). Read beats are staged through a
// 2-entry output FIFO. Start addresses beyond the ROM give a single error beat.
module rom_burst_arbiter #(
    parameter int ROM_DEPTH = 768,
    parameter int AW        = 10,
    parameter int LW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [LW-1:0] req0_len,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [LW-1:0] req1_len,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_id,
    output logic          out_last,
    output logic          out_err
);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    // Widened by one bit so ROM_DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(ROM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);

    // FIFO entry layout: {err, last, id, data}
    localparam int EW = 11;

    state_t        state_q;
    logic          prio_q;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] rem_q;
    logic          id_q;
    logic          err_q;

    logic          rd_vld_p1;
    logic          rd_last_p1;

    logic [EW-1:0] fifo_mem [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    cnt_q;

    logic          gnt_id;
    logic          accept;
    logic [AW-1:0] sel_addr;
    logic [LW-1:0] sel_len;
    logic          sel_oor;
    logic [1:0]    occ;
    logic          err_push;
    logic          push;
    logic          pop;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + AW'(1);
    endfunction

    // Round-robin grant, offered combinationally while idle.
    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        accept     = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        sel_addr   = gnt_id ? req1_addr : req0_addr;
        sel_len    = gnt_id ? req1_len : req0_len;
        sel_oor    = {1'b0, sel_addr} >= DEPTH_W;
    end

    // Read issue throttled so FIFO entries plus reads in flight never exceed two.
    always_comb begin
        occ        = cnt_q + {1'b0, rd_vld_p1};
        rom_en     = (state_q == BURST) && !err_q && (occ < 2'd2);
        rom_addr   = addr_q;
        err_push   = (state_q == BURST) && err_q;
        push       = rd_vld_p1 || err_push;
        push_entry = err_push ? {1'b1, 1'b1, id_q, 8'h00}
                              : {1'b0, rd_last_p1, id_q, rom_data};
        out_valid  = (cnt_q != 2'd0);
        pop        = out_valid && out_ready;
        head       = fifo_mem[rd_ptr_q];
        {out_err, out_last, out_id, out_data} = out_valid ? head : '0;
    end

    // Burst control FSM plus the one-cycle ROM read-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            rd_vld_p1 <= 1'b0;
        end else begin
            // ---- ROM read stage p0 -> p1 ----
            rd_vld_p1  <= rom_en;
            rd_last_p1 <= rom_en && (rem_q == '0);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= sel_addr;
                        rem_q   <= sel_len;
                        id_q    <= gnt_id;
                        err_q   <= sel_oor;
                        prio_q  <= ~gnt_id;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (err_q) begin
                        state_q <= DRAIN;
                    end else if (rom_en) begin
                        addr_q <= next_addr(addr_q);
                        rem_q  <= rem_q - LW'(1);
                        if (rem_q == '0) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt_q == 2'd0 && !rd_vld_p1) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output FIFO pointers and occupancy; simultaneous push/pop holds occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage; contents are only visible when counted valid.
    always_ff @(posedge clk) begin
        // ---- output capture stage p1 -> FIFO ----
        if (push) fifo_mem[wr_ptr_q] <= push_entry;
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Self-checking bench for rom_burst_arbiter: directed scenarios followed by
// randomized bursts, checked against a queue-based transaction model.
module tb_rom_burst_arbiter;

    localparam int AW    = 10;
    localparam int LW    = 4;
    localparam int DEPTH = 768;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [LW-1:0] req0_len, req1_len;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          out_valid, out_ready, out_id, out_last, out_err;
    logic [7:0]    out_data;

    always #5 clk = ~clk;

    rom_burst_arbiter #(.ROM_DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_len(req1_len),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_last(out_last), .out_err(out_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // ROM contents: arbitrary but address-dependent pattern.
    function automatic logic [7:0] rom_f(input int a);
        int v;
        v = a * 37 + 11;
        return v[7:0];
    endfunction

    // ROM model: data appears one cycle after the strobe, garbage otherwise.
    always @(posedge clk) rom_data <= rom_en ? rom_f(int'(rom_addr)) : 8'($urandom);

    // Transaction model
    logic [10:0]   exp_q[$];
    logic [AW-1:0] addr_exp_q[$];
    int            grant_log[$];
    bit            prio = 1'b0;
    int            issued = 0;
    int            popped = 0;
    int            beats_seen = 0;
    bit            prev_stall = 1'b0;
    logic [10:0]   prev_beat;
    bit            rand_ready = 1'b0;
    bit            eg;

    task automatic model_accept(input bit id, input logic [AW-1:0] a, input logic [LW-1:0] l);
        if (int'(a) >= DEPTH) begin
            exp_q.push_back({1'b1, 1'b1, id, 8'h00});
        end else begin
            for (int i = 0; i <= int'(l); i++) begin
                int ad;
                ad = (int'(a) + i) % DEPTH;
                addr_exp_q.push_back(AW'(ad));
                exp_q.push_back({1'b0, (i == int'(l)), id, rom_f(ad)});
            end
        end
    endtask

    // Monitor: grants, ROM reads, output beats and stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (req0_ready || req1_ready) begin
                eg = (req0_valid && req1_valid) ? prio : req1_valid;
                check("grant", {req1_ready, req0_ready},
                      (req0_valid || req1_valid) ? (eg ? 2'b10 : 2'b01) : 2'b00);
                grant_log.push_back(req1_ready ? 1 : 0);
                model_accept(eg, eg ? req1_addr : req0_addr, eg ? req1_len : req0_len);
                prio = ~eg;
            end
            if (rom_en) begin
                if (addr_exp_q.size() == 0) check("rom_unexpected", 1, 0);
                else check("rom_addr", rom_addr, addr_exp_q.pop_front());
                check("outstanding_lt2", ((issued - popped) < 2) ? 1 : 0, 1);
                issued++;
            end
            if (prev_stall)
                check("stall_stable", {out_valid, out_err, out_last, out_id, out_data}, {1'b1, prev_beat});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
                else check("beat", {out_err, out_last, out_id, out_data}, exp_q.pop_front());
                if (!out_err) popped++;
                beats_seen++;
            end
            prev_stall <= out_valid && !out_ready;
            prev_beat  <= {out_err, out_last, out_id, out_data};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input bit id, input logic [AW-1:0] a, input logic [LW-1:0] l, input bit scramble);
        bit ok;
        ok = 1'b0;
        if (id) begin req1_addr = a; req1_len = l; req1_valid = 1'b1; end
        else    begin req0_addr = a; req0_len = l; req0_valid = 1'b1; end
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) ok = 1'b1;
            else if (scramble) begin
                if (id) begin req1_addr = AW'($urandom_range(0, 1023)); req1_len = LW'($urandom); end
                else    begin req0_addr = AW'($urandom_range(0, 1023)); req0_len = LW'($urandom); end
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && (exp_q.size() != 0 || addr_exp_q.size() != 0); i++) step();
        check("drain", exp_q.size() + addr_exp_q.size(), 0);
        repeat (2) step();
    endtask

    int b0;
    int i0;
    bit id_r;
    logic [AW-1:0] a_r;
    int sel;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_len = '0; req1_len = '0;
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_rom_en", rom_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_err", out_err, 0);
        step();
        rst = 1'b0;

        // Both requesters persistent: grants alternate starting at req0.
        req0_addr = 10'h100; req0_len = '0; req1_addr = 10'h200; req1_len = '0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 400 && grant_log.size() < 4; i++) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("arb_grants", grant_log.size(), 4);
        if (grant_log.size() >= 4) begin
            check("arb_g0", grant_log[0], 0);
            check("arb_g1", grant_log[1], 1);
            check("arb_g2", grant_log[2], 0);
            check("arb_g3", grant_log[3], 1);
        end
        wait_drain();

        // Simple burst; first read one cycle after accept.
        b0 = beats_seen;
        send(1'b0, 10'h010, 4'd3, 1'b0);
        @(negedge clk);
        check("r033_first_en", rom_en, 1);
        check("r033_first_addr", rom_addr, 10'h010);
        wait_drain();
        check("r033_beats", beats_seen - b0, 4);

        // Wrap at the top of the ROM.
        b0 = beats_seen;
        send(1'b1, 10'd765, 4'd4, 1'b0);
        wait_drain();
        check("r034_beats", beats_seen - b0, 5);

        // Out-of-range start address.
        b0 = beats_seen; i0 = issued;
        send(1'b0, 10'd800, 4'd7, 1'b0);
        wait_drain();
        check("r036_beats", beats_seen - b0, 1);
        check("r036_no_reads", issued - i0, 0);

        // Long stall: reads stop at two outstanding.
        b0 = beats_seen; i0 = issued;
        out_ready = 1'b0;
        send(1'b0, 10'h020, 4'd15, 1'b0);
        repeat (10) step();
        @(negedge clk);
        check("r037_reads_held", issued - i0, 2);
        check("r037_no_beats", beats_seen - b0, 0);
        out_ready = 1'b1;
        wait_drain();
        check("r037_beats", beats_seen - b0, 16);

        // Reset in the middle of a burst.
        b0 = beats_seen;
        send(1'b1, 10'h040, 4'd7, 1'b0);
        for (int i = 0; i < 200 && beats_seen < b0 + 2; i++) step();
        check("r038_progress", beats_seen - b0, 2);
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 10'h300; req0_len = 4'd1;
        step();
        exp_q.delete(); addr_exp_q.delete(); prio = 1'b0; popped = issued;
        @(negedge clk);
        check("r038_out_valid", out_valid, 0);
        check("r038_rom_en", rom_en, 0);
        check("r038_ready_in_rst", {req1_ready, req0_ready}, 0);
        step();
        req0_valid = 1'b0;
        rst = 1'b0;
        step();
        b0 = beats_seen;
        send(1'b0, 10'h2FE, 4'd5, 1'b0);
        wait_drain();
        check("r038_after_beats", beats_seen - b0, 6);

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            id_r = 1'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      a_r = AW'(768 + $urandom_range(0, 255));
            else if (sel == 1) a_r = AW'(760 + $urandom_range(0, 7));
            else               a_r = AW'($urandom_range(0, 767));
            send(id_r, a_r, LW'($urandom), 1'b1);
        end
        wait_drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_burst_arbiter.md
ROM_BURST_ARBITER -- requirements
Module: rom_burst_arbiter

Interface
REQ-001 Parameters SHALL be: ROM_DEPTH, default 768, number of valid ROM words; AW, default 10, address width; LW, default 4, burst-length field width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has a burst request pending.
REQ-005 reqN_ready  output  1  request N accepted this cycle (transfer when valid & ready).
REQ-006 reqN_addr  input  AW  start word address for requester N.
REQ-007 reqN_len  input  LW  burst length minus one (0 = 1 word, 15 = 16 words).
REQ-008 rom_en  output  1  ROM read strobe.
REQ-009 rom_addr  output  AW  ROM read address, valid when rom_en=1.
REQ-010 rom_data  input  8  ROM read data, valid exactly one cycle after rom_en.
REQ-011 out_valid  output  1  output beat available.
REQ-012 out_ready  input  1  consumer accepts beat (transfer when valid & ready).
REQ-013 out_data  output  8  beat data.
REQ-014 out_id  output  1  requester index that owns the beat.
REQ-015 out_last  output  1  final beat of the burst.
REQ-016 out_err  output  1  beat is an error response (start address out of range).

Function
REQ-017 The FSM SHALL have states IDLE, BURST, DRAIN.
REQ-018 In IDLE, when any reqN_valid=1, the block SHALL assert reqN_ready for exactly one granted requester in the same cycle (combinational), latch addr/len/id, and go to BURST next cycle.
REQ-019 Arbitration SHALL be round-robin: a priority pointer favours req0 after reset and moves to the non-granted requester after every grant; a lone requester is always granted.
REQ-020 reqN_ready SHALL be 0 in BURST and DRAIN.
REQ-021 In BURST, rom_en SHALL assert in any cycle where (output-buffer occupancy + reads in flight) < 2, with rom_addr = current address.
REQ-022 After each issued read the address SHALL increment; ROM_DEPTH-1 SHALL wrap to 0 (767 -> 0).
REQ-023 Exactly len+1 reads SHALL be issued per burst; after the last is issued FSM SHALL go to DRAIN.
REQ-024 DRAIN SHALL return to IDLE in the cycle after the output buffer is empty and no read is in flight; no overlap of bursts.
REQ-025 rom_data SHALL be captured one cycle after rom_en into a 2-entry output FIFO tagged with id, last (on final read) and err=0; the FIFO SHALL never overflow.
REQ-026 out_valid SHALL equal FIFO non-empty; out_data/out_id/out_last/out_err SHALL reflect the head entry and remain stable while out_valid=1 and out_ready=0.
REQ-027 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-028 Start address >= ROM_DEPTH SHALL be accepted, issue no ROM reads, and produce one beat: out_data=0x00, out_err=1, out_last=1, out_id=owner, regardless of len.
REQ-029 Out-of-range checking SHALL apply to the start address only; in-range bursts wrap per REQ-022.
REQ-030 Requests changing while not ready SHALL be ignored; fields are sampled only on the accepting cycle.

Reset
REQ-031 While rst=1 (synchronous), FSM SHALL enter IDLE, FIFO and in-flight count clear, pointer favours req0; at the next edge outputs SHALL be rom_en=0, out_valid=0, req0_ready=req1_ready=0 while rst is high, out_data/out_id/out_last/out_err=0.
REQ-032 Reset mid-burst SHALL abort the burst; returning ROM data for an aborted read SHALL be discarded.

Verification
REQ-033 req0 addr=0x010 len=3, out_ready=1 -> rom_addr 0x010..0x013, four beats id=0, last on 4th, rom_en first asserted one cycle after accept.
REQ-034 req1 addr=765 len=4 -> rom_addr 765,766,767,0,1; five beats, out_last on addr-1 data.
REQ-035 req0 and req1 valid together, both persistent, len=0 -> grants alternate 0,1,0,1; after reset first grant is req0.
REQ-036 req0 addr=800 len=7 -> no rom_en; single beat out_data=0x00 out_err=1 out_last=1 id=0.
REQ-037 len=15, out_ready held 0 for 10 cycles -> at most 2 reads outstanding, out_data stable, all 16 beats delivered in order after release.
REQ-038 rst=1 asserted during 3rd beat of a len=7 burst -> next cycle out_valid=0, rom_en=0, FSM IDLE; new request after reset served correctly.
